// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES state permuter.
// Mode encoding and per-row ShiftRows offsets.
package aes_pkg;

  typedef enum logic [1:0] {
    PM_PASS      = 2'b00,
    PM_TRANSPOSE = 2'b01,
    PM_SHIFT     = 2'b10,
    PM_INVSHIFT  = 2'b11
  } perm_mode_e;

  // Rijndael row rotation: {0,1,2,3} for NB=4/6, {0,1,3,4} for NB=8
  function automatic int shift_off(input int nb, input int row);
    if (nb == 8 && row >= 2) return row + 1;
    return row;
  endfunction

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

endpackage

// File: rtl/aes_skid_buffer.sv
// Two-entry valid/ready elastic stage: output register plus skid register.
// in_ready comes straight from a flop, never from out_ready.
module aes_skid_buffer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          out_v_q, out_v_d;
  logic [DW-1:0] out_d_q, out_d_d;
  logic          skid_v_q, skid_v_d;
  logic [DW-1:0] skid_d_q, skid_d_d;

  // Next state: drain skid first, else load or park the incoming beat
  always_comb begin
    out_v_d  = out_v_q;
    out_d_d  = out_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (skid_v_q) begin
      if (out_ready) begin
        out_d_d  = skid_d_q;
        skid_v_d = 1'b0;
      end
    end else if (!out_v_q || out_ready) begin
      out_v_d = in_valid;
      if (in_valid) out_d_d = in_data;
    end else if (in_valid) begin
      skid_v_d = 1'b1;
      skid_d_d = in_data;
    end
  end

  // State registers; reset drops any buffered beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q  <= 1'b0;
      out_d_q  <= '0;
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
    end else begin
      out_v_q  <= out_v_d;
      out_d_q  <= out_d_d;
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
    end
  end

  assign in_ready  = ~skid_v_q;
  assign out_valid = out_v_q;
  assign out_data  = out_d_q;

endmodule

// File: rtl/aes_state_permute.sv
// Registered byte permuter for the AES state (4 x NB).
// Permutes on the input side, then buffers {tag, data}.
module aes_state_permute
  import aes_pkg::*;
#(
  parameter  int NB    = 4,
  parameter  int TAG_W = 4,
  localparam int W     = 32 * NB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [W-1:0]     out_data
);

  if (!nb_legal(NB)) begin : g_nb_err
    $error("aes_state_permute: NB must be 4, 6 or 8");
  end

  logic [W-1:0] tr_w;
  logic [W-1:0] sh_w;
  logic [W-1:0] ish_w;
  logic [W-1:0] perm_data;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int K  = r + 4 * c;
      localparam int T  = r * NB + c;
      localparam int SH = shift_off(NB, r);
      localparam int CS = (c + SH) % NB;
      localparam int CI = (c - SH + NB) % NB;
      assign tr_w[W-1-8*T -: 8]  = in_data[W-1-8*K -: 8];
      assign sh_w[W-1-8*K -: 8]  = in_data[W-1-8*(r+4*CS) -: 8];
      assign ish_w[W-1-8*K -: 8] = in_data[W-1-8*(r+4*CI) -: 8];
    end
  end

  // Select the permutation for this beat
  always_comb begin
    perm_data = in_data;
    unique case (perm_mode_e'(in_mode))
      PM_PASS:      perm_data = in_data;
      PM_TRANSPOSE: perm_data = tr_w;
      PM_SHIFT:     perm_data = sh_w;
      PM_INVSHIFT:  perm_data = ish_w;
      default:      perm_data = in_data;
    endcase
  end

  aes_skid_buffer #(
    .DW(W + TAG_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_tag, perm_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_tag, out_data})
  );

endmodule

// File: tb/tb_aes_state_permute.sv
// Scoreboard bench for aes_state_permute, NB=4 and NB=8.
// Inputs driven on negedge; outputs sampled there too.
module tb_aes_state_permute;

  localparam logic [127:0] P4 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T4 = 128'h0004080c0105090d02060a0e03070b0f;
  localparam logic [127:0] S4 = 128'h00050a0f04090e03080d02070c01060b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         in_valid4 = 0, in_ready4, out_valid4, out_ready4 = 0;
  logic [1:0]   in_mode4 = 0;
  logic [3:0]   in_tag4 = 0, out_tag4;
  logic [127:0] in_data4 = 0, out_data4;

  logic         in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 0;
  logic [1:0]   in_mode8 = 0;
  logic [3:0]   in_tag8 = 0, out_tag8;
  logic [255:0] in_data8 = 0, out_data8;

  logic [131:0] sb4[$];
  logic [259:0] sb8[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  aes_state_permute #(.NB(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_mode(in_mode4), .in_tag(in_tag4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_tag(out_tag4), .out_data(out_data4)
  );

  aes_state_permute #(.NB(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_mode(in_mode8), .in_tag(in_tag8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_tag(out_tag8), .out_data(out_data8)
  );

  // Reference model; state left-aligned in 256 bits
  function automatic logic [255:0] ref_perm(input int nb, input logic [1:0] m,
                                            input logic [255:0] din);
    logic [7:0] s[4][8];
    logic [255:0] o;
    int sh;
    o = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = din[255-8*(r+4*c) -: 8];
    for (int r = 0; r < 4; r++) begin
      sh = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        case (m)
          2'd0: o[255-8*(r+4*c) -: 8] = s[r][c];
          2'd1: o[255-8*(r*nb+c) -: 8] = s[r][c];
          2'd2: o[255-8*(r+4*c) -: 8] = s[r][(c+sh)%nb];
          default: o[255-8*(r+4*c) -: 8] = s[r][(c+nb-sh)%nb];
        endcase
      end
    end
    return o;
  endfunction

  task automatic step4(input logic v, input logic [1:0] m, input logic [3:0] t,
                       input logic [127:0] d, input logic ordy,
                       output logic acc, output logic of, output logic [131:0] ob);
    logic [255:0] e;
    in_valid4 = v; in_mode4 = m; in_tag4 = t; in_data4 = d; out_ready4 = ordy;
    acc = v && in_ready4;
    of = out_valid4 && ordy;
    ob = {out_tag4, out_data4};
    if (acc) begin
      e = ref_perm(4, m, {d, 128'b0});
      sb4.push_back({t, e[255:128]});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step8(input logic v, input logic [1:0] m, input logic [3:0] t,
                       input logic [255:0] d, input logic ordy,
                       output logic acc, output logic of, output logic [259:0] ob);
    in_valid8 = v; in_mode8 = m; in_tag8 = t; in_data8 = d; out_ready8 = ordy;
    acc = v && in_ready8;
    of = out_valid8 && ordy;
    ob = {out_tag8, out_data8};
    if (acc) sb8.push_back({t, ref_perm(8, m, d)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    vectors++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset4_hs: valid=%b ready=%b want 0 1", out_valid4, in_ready4);
    end
    vectors++;
    if (out_data4 !== '0 || out_tag4 !== '0) begin
      miscompares++;
      $display("FAIL reset4_data: %h/%h want 0", out_tag4, out_data4);
    end
    vectors++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || out_data8 !== '0) begin
      miscompares++;
      $display("FAIL reset8: valid=%b ready=%b data=%h", out_valid8, in_ready8, out_data8);
    end
  endtask

  task automatic test_pass_transpose;
    logic acc, of;
    logic [131:0] ob, e;
    logic [131:0] want[2];
    want[0] = {4'h1, P4};
    want[1] = {4'h2, T4};
    step4(1, 2'd0, 4'h1, P4, 1, acc, of, ob);
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL pass_accept: got %b want 1", acc);
    end
    step4(1, 2'd1, 4'h2, P4, 1, acc, of, ob);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) step4(0, 2'd0, 4'h0, '0, 1, acc, of, ob);
      vectors++;
      if (of !== 1'b1) begin
        miscompares++;
        $display("FAIL pt_latency%0d: out_valid %b want 1", i, of);
      end else begin
        e = sb4.pop_front();
        vectors++;
        if (ob !== e || ob !== want[i]) begin
          miscompares++;
          $display("FAIL pt_data%0d: got %h want %h", i, ob, want[i]);
        end
      end
    end
    sb4.delete();
  endtask

  task automatic test_shift_roundtrip4;
    logic acc, of;
    logic [131:0] ob, e;
    logic [131:0] got[$];
    step4(1, 2'd2, 4'h3, P4, 1, acc, of, ob);
    step4(1, 2'd3, 4'h5, S4, 1, acc, of, ob);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step4(0, 2'd0, 4'h0, '0, 1, acc, of, ob);
      if (of) begin
        got.push_back(ob);
        e = sb4.pop_front();
        vectors++;
        if (ob !== e) begin
          miscompares++;
          $display("FAIL shift4_model: got %h want %h", ob, e);
        end
      end
    end
    vectors++;
    if (got.size() != 2) begin
      miscompares++;
      $display("FAIL shift4_count: got %0d want 2", got.size());
    end else begin
      vectors++;
      if (got[0] !== {4'h3, S4} || got[1] !== {4'h5, P4}) begin
        miscompares++;
        $display("FAIL shift4_const: got %h %h", got[0], got[1]);
      end
    end
    sb4.delete();
  endtask

  task automatic test_nb8;
    logic acc, of;
    logic [259:0] ob, e;
    logic [259:0] got[$];
    logic [255:0] d8, s8;
    logic [7:0] b3, b2;
    int n;
    for (int j = 0; j < 32; j++) d8[255-8*j -: 8] = 8'(j);
    s8 = ref_perm(8, 2'd2, d8);
    n = 0;
    for (int i = 0; i < 40 && (n < 8 || sb8.size() > 0); i++) begin
      logic [255:0] d;
      logic [1:0] m;
      case (n)
        0: begin d = d8; m = 2'd2; end
        1: begin d = s8; m = 2'd3; end
        2: begin d = d8; m = 2'd0; end
        3: begin d = d8; m = 2'd1; end
        default: begin
          d = {8{$urandom()}};
          m = 2'(n);
        end
      endcase
      step8(n < 8, m, 4'(n), d, 1'b1, acc, of, ob);
      if (acc) n++;
      if (of) begin
        got.push_back(ob);
        e = sb8.pop_front();
        vectors++;
        if (ob !== e) begin
          miscompares++;
          $display("FAIL nb8_model: got %h want %h", ob, e);
        end
      end
    end
    vectors++;
    if (got.size() != 8) begin
      miscompares++;
      $display("FAIL nb8_count: got %0d want 8", got.size());
    end else begin
      e = got[0];
      b3 = e[255-24 -: 8];
      b2 = e[255-16 -: 8];
      vectors++;
      if (b3 !== 8'h13 || b2 !== 8'h0e) begin
        miscompares++;
        $display("FAIL nb8_rot: row3=%h row2=%h want 13 0e", b3, b2);
      end
      vectors++;
      if (got[1] !== {4'h1, d8}) begin
        miscompares++;
        $display("FAIL nb8_roundtrip: got %h want %h", got[1], {4'h1, d8});
      end
    end
    sb8.delete();
  endtask

  task automatic test_backpressure;
    logic acc, of, ordy;
    logic [131:0] ob, e;
    logic [127:0] bd[10];
    int sent, occ, outs, cyc;
    sent = 0; occ = 0; outs = 0; cyc = 0;
    for (int i = 0; i < 10; i++) bd[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    while ((sent < 10 || sb4.size() > 0) && cyc < 300) begin
      ordy = ($urandom_range(0, 9) >= 3);
      vectors++;
      if (in_ready4 !== (occ < 2) || out_valid4 !== (occ > 0)) begin
        miscompares++;
        $display("FAIL bp_flags: ready=%b valid=%b occ=%0d", in_ready4, out_valid4, occ);
      end
      step4(sent < 10, 2'(sent), 4'(sent), bd[sent % 10], ordy, acc, of, ob);
      if (acc) sent++;
      occ = occ + int'(acc) - int'(of);
      if (of) begin
        outs++;
        e = sb4.pop_front();
        vectors++;
        if (ob !== e) begin
          miscompares++;
          $display("FAIL bp_order: got %h want %h", ob, e);
        end
      end
      cyc++;
    end
    vectors++;
    if (outs != 10) begin
      miscompares++;
      $display("FAIL bp_count: got %0d beats want 10", outs);
    end
    sb4.delete();
  endtask

  task automatic test_back_to_back;
    logic acc, of;
    logic [131:0] ob, e;
    for (int i = 0; i <= 10; i++) begin
      step4(i < 10, 2'(i), 4'(i), {4{$urandom()}}, 1'b1, acc, of, ob);
      if (i < 10) begin
        vectors++;
        if (acc !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_accept%0d: got %b want 1", i, acc);
        end
      end
      if (i > 0) begin
        vectors++;
        if (of !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_bubble%0d: out_valid %b want 1", i, of);
        end else begin
          e = sb4.pop_front();
          vectors++;
          if (ob !== e) begin
            miscompares++;
            $display("FAIL b2b_data%0d: got %h want %h", i, ob, e);
          end
        end
      end
    end
    sb4.delete();
  endtask

  task automatic test_reset_mid;
    logic acc, of;
    logic [131:0] ob;
    step4(1, 2'd0, 4'h7, P4, 0, acc, of, ob);
    step4(1, 2'd1, 4'h8, P4, 0, acc, of, ob);
    vectors++;
    if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0) begin
      miscompares++;
      $display("FAIL rstm_full: valid=%b ready=%b want 1 0", out_valid4, in_ready4);
    end
    in_valid4 = 0;
    #2 rst_n = 0;
    #1;
    vectors++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || out_data4 !== '0 || out_tag4 !== '0) begin
      miscompares++;
      $display("FAIL rstm_async: valid=%b ready=%b data=%h", out_valid4, in_ready4, out_data4);
    end
    sb4.delete();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      step4(0, 2'd0, 4'h0, '0, 1, acc, of, ob);
      vectors++;
      if (of !== 1'b0) begin
        miscompares++;
        $display("FAIL rstm_stale%0d: out_valid %b want 0", i, of);
      end
    end
    step4(1, 2'd1, 4'h9, P4, 1, acc, of, ob);
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL rstm_accept: got %b want 1", acc);
    end
    step4(0, 2'd0, 4'h0, '0, 1, acc, of, ob);
    vectors++;
    if (of !== 1'b1 || ob !== {4'h9, T4}) begin
      miscompares++;
      $display("FAIL rstm_first: valid=%b got %h want %h", of, ob, {4'h9, T4});
    end
    sb4.delete();
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1;
    test_pass_transpose();
    test_shift_roundtrip4();
    test_nb8();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
